// File: rtl/rtc_lectura_fecha_hora_pkg.sv
// Shared RTC register map, FSM states and per-field BCD limits for the
// time/date read sequencer (addresses are also used by the write path).
package rtc_pkg;

   localparam int unsigned NUM_CAMPOS = 7;

   localparam logic [7:0] ADDR_SEG  = 8'h21;
   localparam logic [7:0] ADDR_MIN  = 8'h22;
   localparam logic [7:0] ADDR_HORA = 8'h23;
   localparam logic [7:0] ADDR_DIA  = 8'h24;
   localparam logic [7:0] ADDR_MES  = 8'h25;
   localparam logic [7:0] ADDR_ANIO = 8'h26;
   localparam logic [7:0] ADDR_DSEM = 8'h27;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP,
      ST_CHECK,
      ST_COMMIT,
      ST_FAIL
   } estado_t;

   function automatic logic [7:0] campo_addr(input logic [2:0] idx);
      logic [7:0] a;
      case (idx)
         3'd0:    a = ADDR_SEG;
         3'd1:    a = ADDR_MIN;
         3'd2:    a = ADDR_HORA;
         3'd3:    a = ADDR_DIA;
         3'd4:    a = ADDR_MES;
         3'd5:    a = ADDR_ANIO;
         3'd6:    a = ADDR_DSEM;
         default: a = 8'h00;
      endcase
      return a;
   endfunction

   // Limits are BCD-coded; for valid BCD, binary ordering matches decimal.
   function automatic logic [7:0] campo_min(input int unsigned i);
      logic [7:0] m;
      case (i)
         3, 4, 6: m = 8'h01;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

   function automatic logic [7:0] campo_max(input int unsigned i);
      logic [7:0] m;
      case (i)
         0, 1:    m = 8'h59;
         2:       m = 8'h23;
         3:       m = 8'h31;
         4:       m = 8'h12;
         5:       m = 8'h99;
         6:       m = 8'h07;
         default: m = 8'h00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/rtc_lectura_fecha_hora_bcd_rango_chk.sv
// Combinational BCD validator: both nibbles must be decimal digits and the
// byte must lie within [min_val, max_val].
module bcd_rango_chk (
   input  logic [7:0] dato,
   input  logic [7:0] min_val,
   input  logic [7:0] max_val,
   output logic       valid
);

   always_comb begin
      valid = (dato[7:4] <= 4'd9) && (dato[3:0] <= 4'd9) &&
              (dato >= min_val) && (dato <= max_val);
   end

endmodule

// File: rtl/rtc_lectura_fecha_hora.sv
// Read sequencer: fetches the seven RTC time/date registers, validates them
// and commits a consistent snapshot only when every field is valid.
module rtc_lectura_fecha_hora
   import rtc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       err_rango,
   output logic       err_timeout,
   output logic       rd_req,
   output logic [7:0] rd_addr,
   input  logic       rd_ack,
   input  logic [7:0] rd_data,
   output logic [7:0] seg,
   output logic [7:0] min,
   output logic [7:0] hora,
   output logic [7:0] dia,
   output logic [7:0] mes,
   output logic [7:0] anio,
   output logic [2:0] dia_semana
);

   localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

   estado_t              estado_q, estado_d;
   logic                 start_q;
   logic [2:0]           idx_q, idx_d;
   logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
   logic [7:0]           shadow_q [NUM_CAMPOS];
   logic [7:0]           shadow_d [NUM_CAMPOS];
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_rango_q, err_rango_d;
   logic                 err_timeout_q, err_timeout_d;
   logic                 rd_req_q, rd_req_d;
   logic [7:0]           rd_addr_q, rd_addr_d;
   logic [7:0]           seg_q, seg_d, min_q, min_d, hora_q, hora_d;
   logic [7:0]           dia_q, dia_d, mes_q, mes_d, anio_q, anio_d;
   logic [2:0]           dsem_q, dsem_d;
   logic [NUM_CAMPOS-1:0] campo_ok;
   logic                 start_edge;

   for (genvar g = 0; g < NUM_CAMPOS; g++) begin : g_chk
      bcd_rango_chk u_chk (
         .dato    (shadow_q[g]),
         .min_val (campo_min(g)),
         .max_val (campo_max(g)),
         .valid   (campo_ok[g])
      );
   end

   assign start_edge = start && !start_q;

   // Outputs, done and busy are registered, so COMMIT/FAIL effects are
   // applied on the transition out of CHECK/REQ; those states only hold done.
   always_comb begin
      estado_d      = estado_q;
      idx_d         = idx_q;
      to_cnt_d      = to_cnt_q;
      shadow_d      = shadow_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      err_rango_d   = err_rango_q;
      err_timeout_d = err_timeout_q;
      rd_req_d      = rd_req_q;
      rd_addr_d     = rd_addr_q;
      seg_d         = seg_q;
      min_d         = min_q;
      hora_d        = hora_q;
      dia_d         = dia_q;
      mes_d         = mes_q;
      anio_d        = anio_q;
      dsem_d        = dsem_q;
      case (estado_q)
         ST_IDLE: begin
            if (start_edge) begin
               err_rango_d   = 1'b0;
               err_timeout_d = 1'b0;
               idx_d         = '0;
               to_cnt_d      = '0;
               busy_d        = 1'b1;
               rd_req_d      = 1'b1;
               rd_addr_d     = campo_addr(3'd0);
               estado_d      = ST_REQ;
            end
         end
         ST_REQ: begin
            if (rd_ack) begin
               shadow_d[idx_q] = rd_data;
               rd_req_d        = 1'b0;
               estado_d        = ST_GAP;
            end else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
               rd_req_d      = 1'b0;
               err_timeout_d = 1'b1;
               busy_d        = 1'b0;
               done_d        = 1'b1;
               estado_d      = ST_FAIL;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ST_GAP: begin
            if (idx_q == 3'(NUM_CAMPOS - 1)) begin
               estado_d = ST_CHECK;
            end else begin
               idx_d     = idx_q + 3'd1;
               to_cnt_d  = '0;
               rd_req_d  = 1'b1;
               rd_addr_d = campo_addr(idx_q + 3'd1);
               estado_d  = ST_REQ;
            end
         end
         ST_CHECK: begin
            busy_d = 1'b0;
            done_d = 1'b1;
            if (&campo_ok) begin
               seg_d    = shadow_q[0];
               min_d    = shadow_q[1];
               hora_d   = shadow_q[2];
               dia_d    = shadow_q[3];
               mes_d    = shadow_q[4];
               anio_d   = shadow_q[5];
               dsem_d   = shadow_q[6][2:0] - 3'd1;
               estado_d = ST_COMMIT;
            end else begin
               err_rango_d = 1'b1;
               estado_d    = ST_FAIL;
            end
         end
         ST_COMMIT, ST_FAIL: estado_d = ST_IDLE;
         default:            estado_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q      <= ST_IDLE;
         start_q       <= 1'b0;
         idx_q         <= '0;
         to_cnt_q      <= '0;
         for (int unsigned i = 0; i < NUM_CAMPOS; i++) shadow_q[i] <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_rango_q   <= 1'b0;
         err_timeout_q <= 1'b0;
         rd_req_q      <= 1'b0;
         rd_addr_q     <= 8'h00;
         seg_q         <= 8'h00;
         min_q         <= 8'h00;
         hora_q        <= 8'h00;
         dia_q         <= 8'h01;
         mes_q         <= 8'h01;
         anio_q        <= 8'h00;
         dsem_q        <= 3'd0;
      end else begin
         estado_q      <= estado_d;
         start_q       <= start;
         idx_q         <= idx_d;
         to_cnt_q      <= to_cnt_d;
         shadow_q      <= shadow_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_rango_q   <= err_rango_d;
         err_timeout_q <= err_timeout_d;
         rd_req_q      <= rd_req_d;
         rd_addr_q     <= rd_addr_d;
         seg_q         <= seg_d;
         min_q         <= min_d;
         hora_q        <= hora_d;
         dia_q         <= dia_d;
         mes_q         <= mes_d;
         anio_q        <= anio_d;
         dsem_q        <= dsem_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign err_rango   = err_rango_q;
   assign err_timeout = err_timeout_q;
   assign rd_req      = rd_req_q;
   assign rd_addr     = rd_addr_q;
   assign seg         = seg_q;
   assign min         = min_q;
   assign hora        = hora_q;
   assign dia         = dia_q;
   assign mes         = mes_q;
   assign anio        = anio_q;
   assign dia_semana  = dsem_q;

endmodule

// File: tb/tb_rtc_lectura_fecha_hora.sv
// Scoreboard bench for the RTC read sequencer: a bus model answers reads
// from a register table, expected snapshots are queued at each start.
module tb_rtc_lectura_fecha_hora;

   logic       clk, reset, start;
   logic       busy, done, err_rango, err_timeout, rd_req, rd_ack;
   logic [7:0] rd_addr, rd_data;
   logic [7:0] seg, min, hora, dia, mes, anio;
   logic [2:0] dia_semana;

   rtc_lectura_fecha_hora #(.TIMEOUT_CYC(255)) dut (
      .clk (clk), .reset (reset), .start (start), .busy (busy), .done (done),
      .err_rango (err_rango), .err_timeout (err_timeout), .rd_req (rd_req),
      .rd_addr (rd_addr), .rd_ack (rd_ack), .rd_data (rd_data), .seg (seg),
      .min (min), .hora (hora), .dia (dia), .mes (mes), .anio (anio),
      .dia_semana (dia_semana)
   );

   typedef struct {
      logic [7:0] seg, min, hora, dia, mes, anio;
      logic [2:0] dsem;
      logic       e_rango, e_to;
      int         lat;
      int         start_cyc;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       cur;
   int         checks = 0, errors = 0;
   int         cyc = 0, n_done = 0, n_exp = 0;

   logic [7:0] bus_mem [7];
   int         ack_delay = 0;
   logic [7:0] withhold_addr = 8'h00;
   logic       spur_ack = 1'b0;
   int         wait_cnt = 0;
   logic       prev_req = 1'b0;
   logic [7:0] last_addr = 8'h00;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Bus model: ack after ack_delay REQ cycles, data looked up by address
   always @(negedge clk) begin
      if (rd_req) begin
         if (prev_req) chk("rd_addr_stable", rd_addr, last_addr);
         if (rd_addr != withhold_addr && wait_cnt == ack_delay) begin
            rd_ack  = 1'b1;
            rd_data = (rd_addr >= 8'h21 && rd_addr <= 8'h27) ? bus_mem[rd_addr - 8'h21] : 8'hEE;
         end else begin
            rd_ack   = 1'b0;
            wait_cnt = wait_cnt + 1;
         end
      end else begin
         wait_cnt = 0;
         rd_ack   = spur_ack;
         rd_data  = spur_ack ? 8'h09 : 8'h00;
      end
      prev_req  = rd_req;
      last_addr = rd_addr;
   end

   // Monitor: every done pops one expected snapshot
   always @(negedge clk) begin
      if (!reset && done) begin
         n_done++;
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("latency", cyc + 1 - e.start_cyc, e.lat);
            chk("seg", seg, e.seg);
            chk("min", min, e.min);
            chk("hora", hora, e.hora);
            chk("dia", dia, e.dia);
            chk("mes", mes, e.mes);
            chk("anio", anio, e.anio);
            chk("dia_semana", dia_semana, e.dsem);
            chk("err_rango", err_rango, e.e_rango);
            chk("err_timeout", err_timeout, e.e_to);
            chk("busy_at_done", busy, 0);
            chk("rd_req_at_done", rd_req, 0);
         end
      end
   end

   task automatic lanzar(input logic [55:0] v, input logic ok, input logic [2:0] dsem,
                         input logic to, input int lat, input int d, input logic [7:0] wh);
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < 7; i++) bus_mem[i] = v[55 - 8*i -: 8];
      ack_delay     = d;
      withhold_addr = wh;
      e = cur;
      if (ok) begin
         e.seg  = v[55:48]; e.min = v[47:40]; e.hora = v[39:32];
         e.dia  = v[31:24]; e.mes = v[23:16]; e.anio = v[15:8];
         e.dsem = dsem;
         cur    = e;
      end
      e.e_rango   = !ok && !to;
      e.e_to      = to;
      e.lat       = lat;
      e.start_cyc = cyc + 1;
      sb_q.push_back(e);
      n_exp++;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic esperar_done(input int limit);
      for (int i = 0; i < limit && n_done < n_exp; i++) @(negedge clk);
      if (n_done < n_exp) begin
         chk("done_timeout", n_done, n_exp);
         sb_q.delete();
         n_exp = n_done;
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      rd_ack  = 1'b0;
      rd_data = 8'h00;
      for (int i = 0; i < 7; i++) bus_mem[i] = 8'h00;
      cur = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0, 0, 0};
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_rd_addr", rd_addr, 8'h00);
      chk("rst_errs", {err_rango, err_timeout}, 2'b00);
      chk("rst_time", {seg, min, hora}, 24'h000000);
      chk("rst_date", {dia, mes, anio}, 24'h010100);
      chk("rst_dsem", dia_semana, 3'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // valid read, fastest acks
      lanzar(56'h30_45_13_15_04_16_03, 1'b1, 3'd2, 1'b0, 16, 0, 8'h00);
      esperar_done(100);
      // hour out of range, non-BCD minute, weekday 0 and 8
      lanzar(56'h30_45_24_15_04_16_03, 1'b0, 3'd0, 1'b0, 16, 0, 8'h00);
      esperar_done(100);
      lanzar(56'h30_5A_13_15_04_16_03, 1'b0, 3'd0, 1'b0, 16, 0, 8'h00);
      esperar_done(100);
      lanzar(56'h30_45_13_15_04_16_00, 1'b0, 3'd0, 1'b0, 16, 0, 8'h00);
      esperar_done(100);
      lanzar(56'h30_45_13_15_04_16_08, 1'b0, 3'd0, 1'b0, 16, 0, 8'h00);
      esperar_done(100);
      // upper limits on every field
      lanzar(56'h59_59_23_31_12_99_07, 1'b1, 3'd6, 1'b0, 16, 0, 8'h00);
      esperar_done(100);
      // day 32 and month 13 just above range
      lanzar(56'h00_00_00_32_01_00_01, 1'b0, 3'd0, 1'b0, 16, 0, 8'h00);
      esperar_done(100);
      lanzar(56'h00_00_00_01_13_00_01, 1'b0, 3'd0, 1'b0, 16, 0, 8'h00);
      esperar_done(100);
      // ack withheld on third field: done 256 cycles after REQ entry at N+5
      lanzar(56'h11_22_05_10_10_10_01, 1'b1 && 1'b0, 3'd0, 1'b1, 261, 0, 8'h23);
      esperar_done(400);
      // ack delayed 5 cycles per field, extra start edge mid-read
      lanzar(56'h00_00_00_01_01_00_01, 1'b1, 3'd0, 1'b0, 51, 5, 8'h00);
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      esperar_done(200);
      repeat (20) @(negedge clk);

      // acknowledge while idle has no effect
      spur_ack = 1'b1;
      repeat (3) @(negedge clk);
      spur_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_ack_busy", busy, 0);
      chk("idle_ack_seg", seg, cur.seg);

      // reset during the fourth field: no commit, no done
      for (int i = 0; i < 7; i++) bus_mem[i] = 8'h01;
      ack_delay = 0;
      withhold_addr = 8'h00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int k;
         k = 0;
         while (!(rd_req && rd_addr == 8'h24) && k < 50) begin
            @(negedge clk);
            k++;
         end
         chk("reach_field4", k < 50, 1);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_rd_req", rd_req, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_rd_addr", rd_addr, 8'h00);
      chk("midrst_vals", {seg, min, hora, dia, mes, anio}, 48'h000000_010100);
      chk("midrst_dsem", dia_semana, 3'd0);
      reset = 1'b0;
      cur = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0, 0, 0};
      repeat (30) @(negedge clk);

      // sequencer still works after the aborted read
      lanzar(56'h07_08_09_28_02_25_05, 1'b1, 3'd4, 1'b0, 16, 0, 8'h00);
      esperar_done(100);

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rtc_lectura_fecha_hora.md
# rtc_lectura_fecha_hora

Read sequencer that fetches the seven time/date registers from the RTC through the bus controller's read port, validates each BCD byte, and publishes a consistent snapshot to the time-keeping counters. It is the read-side complement of the up/down setting counters: those produce values to write into the RTC, and this block brings RTC contents back. The weekday is returned in the counters' internal 0..6 encoding. A snapshot is committed atomically, only when all seven fields pass validation.

## Interface
- TIMEOUT_CYC, 255: cycles `rd_req` may stay high without `rd_ack` before the read is aborted.
- ADDR_SEG/MIN/HORA/DIA/MES/ANIO/DSEM, 8'h21..8'h27: RTC register addresses, read in this order.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  level or pulse; a rising edge while idle launches a full read.
- busy  out  1  high from the cycle after the accepted start until `done`.
- done  out  1  one-cycle pulse when a read finishes, whether it succeeds or fails.
- err_rango  out  1  last read had an out-of-range or non-BCD field; sticky until next start.
- err_timeout  out  1  last read timed out; sticky until next start.
- rd_req  out  1  read request to the bus controller.
- rd_addr  out  8  register address; stable while `rd_req`=1.
- rd_ack  in  1  controller acknowledge; `rd_data` is valid in the same cycle.
- rd_data  in  8  BCD byte read.
- seg, min, hora, dia, mes, anio  out  8 each  committed BCD values.
- dia_semana  out  3  committed weekday, 0..6, equal to the RTC value minus 1.

## Operation
- Start detection:
  - Edge detector on `start`, using a registered copy.
  - A start edge while `busy` is ignored.
- FSM states: IDLE, REQ, GAP, CHECK, COMMIT, FAIL.
  - IDLE: on a start edge, clear both error flags, clear the field index and go to REQ.
  - REQ: `rd_req`=1 and `rd_addr`=address[idx]. A clock edge with `rd_ack`=1 captures `rd_data` into shadow[idx] and goes to GAP. The timeout counter expiring goes to FAIL and sets `err_timeout`.
  - GAP: `rd_req`=0 for exactly one cycle. If idx=6, go to CHECK; otherwise increment idx and go to REQ.
  - CHECK: check all shadow bytes. Any failure goes to FAIL and sets `err_rango`; otherwise go to COMMIT.
  - COMMIT: copy the shadow registers to the outputs, pulse `done`, go to IDLE.
  - FAIL: outputs stay unchanged, pulse `done`, go to IDLE.
- Validation rules:
  - Both nibbles must be ≤9.
  - Ranges: seg 00–59, min 00–59, hora 00–23, dia 01–31, mes 01–12, anio 00–99, dsem 01–07.
  - No month/day cross-check.
- Weekday conversion: `dia_semana` = dsem[2:0] − 1, computed on 3 bits. It is only computed for validated values, so no wrap occurs.
- Timeout counter:
  - Width is ceil(log2(TIMEOUT_CYC+1)).
  - Cleared on entry to REQ; increments each REQ cycle without ack.
  - Reaching TIMEOUT_CYC in REQ aborts the read.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rd_req`=0, `rd_addr`=8'h00, both error flags 0, seg/min/hora/anio=8'h00, dia=8'h01, mes=8'h01, `dia_semana`=0.
- Reset mid-read: the read is abandoned with no commit and no `done`. `rd_req` is 0 after the reset edge.
- Start edge at edge N: REQ begins at N+1, so `rd_req` is high from N+1.
- Fastest read, with ack in the first REQ cycle:
  - each field takes 2 cycles (REQ+GAP);
  - the fields plus CHECK and COMMIT total 16 cycles;
  - `done` is high in cycle N+16, and the outputs update on the same edge that raises `done`.
- `busy` falls in the same cycle that `done` rises.
- `rd_addr` changes only on entry to REQ.
- An ack arriving outside REQ is ignored.
- Timeout: `done` is high exactly TIMEOUT_CYC+1 cycles after entry to the stalled REQ.
- Start edge coinciding with `done`: ignored, because `busy` was still high on that edge.

## Structure
- Package `rtc_pkg` holds:
  - the register address constants, shared with the write path;
  - state encoding localparams;
  - NUM_CAMPOS=7;
  - per-field min/max limits.
- Sub-module `bcd_rango_chk` is combinational: inputs byte, min, max; output valid (nibble check plus range). Instantiate it 7 times, or once with a mux driven by idx.
- The shadow register file is 7×8 bits.

## Test plan
- Valid read: bus returns 30,45,13,15,04,16,03 with ack in the first cycle → `done` at N+16; seg=8'h30, hora=8'h13, mes=8'h04, `dia_semana`=2; no errors.
- Range error: hora byte 8'h24 → `err_rango`=1, `done` pulses, and all outputs keep their previous values.
- Non-BCD byte: min=8'h5A → `err_rango`; dsem=8'h00 and dsem=8'h08 are each rejected.
- Timeout: ack withheld on the 3rd field → `rd_req` drops, `err_timeout`=1, `done` TIMEOUT_CYC+1 cycles after that REQ entry, no commit.
- Ack delayed 5 cycles per field: `rd_addr` holds steady and the sequence completes correctly. A second start edge sent mid-read is ignored.
- Reset asserted during the 4th field → `rd_req`=0, `busy`=0, reset values on the next cycle, no `done`.
